// File: rtl/accum_sb_pkg.sv
// Shared types and constants for the accumulator scoreboard.
package accum_sb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } sb_state_e;

    localparam int unsigned ERR_W = 8;
    localparam int unsigned IDX_W = 16;

    localparam logic [IDX_W-1:0] IDX_NONE = 16'hFFFF;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Increment an error counter by one on a hit, sticking at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt, input logic hit);
        sat_inc = (hit && (cnt != ERR_MAX)) ? cnt + ERR_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/accum_sb_model.sv
// Golden accumulate-with-bypass model: a running sum plus the bypass mux.
module accum_sb_model
    import accum_sb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed,
    input  logic             advance,
    input  logic [WIDTH-1:0] seed_base,
    input  logic [WIDTH-1:0] accum_in,
    input  logic             accum_bypass,
    output logic [WIDTH-1:0] exp_acc,
    output logic [WIDTH-1:0] exp_byp
);

    logic [WIDTH-1:0] model_q;

    // Seed from the live accumulator at run start, then track it; carry out is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q <= '0;
        end else if (seed) begin
            model_q <= seed_base + accum_in;
        end else if (advance) begin
            model_q <= model_q + accum_in;
        end
    end

    // Expected outputs for the current cycle.
    always_comb begin
        exp_acc = model_q;
        exp_byp = accum_bypass ? accum_in : model_q;
    end

endmodule

// File: rtl/accum_scoreboard.sv
// Windowed scoreboard comparing an accumulator against a golden model.
module accum_scoreboard
    import accum_sb_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CHECK_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] accum_in,
    input  logic             accum_bypass,
    input  logic [WIDTH-1:0] accum_out,
    input  logic [WIDTH-1:0] accum_bypass_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] accum_err_count,
    output logic [ERR_W-1:0] bypass_err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_CYCLES - 1);

    sb_state_e        state_q;
    logic [IDX_W-1:0] idx_q;
    logic [ERR_W-1:0] acc_cnt_q, byp_cnt_q;
    logic [ERR_W-1:0] acc_cnt_d, byp_cnt_d;
    logic [IDX_W-1:0] first_q;
    logic             busy_q, done_q, pass_q, mismatch_q;

    logic             start_fire;
    logic             in_check;
    logic [WIDTH-1:0] exp_acc, exp_byp;
    logic             acc_bad, byp_bad;

    assign start_fire = start && (state_q != StCheck);
    assign in_check   = (state_q == StCheck);

    accum_sb_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed         (start_fire),
        .advance      (in_check),
        .seed_base    (accum_out),
        .accum_in     (accum_in),
        .accum_bypass (accum_bypass),
        .exp_acc      (exp_acc),
        .exp_byp      (exp_byp)
    );

    // Full-width compare; an unknown bit fails the equality test and flags a mismatch.
    always_comb begin
        acc_bad = 1'b1;
        byp_bad = 1'b1;
        if (accum_out == exp_acc) begin
            acc_bad = 1'b0;
        end
        if (accum_bypass_out == exp_byp) begin
            byp_bad = 1'b0;
        end
        acc_cnt_d = sat_inc(acc_cnt_q, acc_bad);
        byp_cnt_d = sat_inc(byp_cnt_q, byp_bad);
    end

    // Run control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_cnt_q  <= '0;
            byp_cnt_q  <= '0;
            first_q    <= IDX_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    mismatch_q <= 1'b0;
                    if (start) begin
                        state_q   <= StCheck;
                        idx_q     <= '0;
                        acc_cnt_q <= '0;
                        byp_cnt_q <= '0;
                        first_q   <= IDX_NONE;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                StCheck: begin
                    acc_cnt_q  <= acc_cnt_d;
                    byp_cnt_q  <= byp_cnt_d;
                    mismatch_q <= acc_bad | byp_bad;
                    idx_q      <= idx_q + IDX_W'(1);
                    // IDX_NONE is never a legal index, so it doubles as "no error yet".
                    if ((acc_bad || byp_bad) && (first_q == IDX_NONE)) begin
                        first_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (acc_cnt_d == '0) && (byp_cnt_d == '0);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch         = mismatch_q;
    assign accum_err_count  = acc_cnt_q;
    assign bypass_err_count = byp_cnt_q;
    assign first_err_idx    = first_q;

endmodule
